xgmii_tx_framer: RTL and testbench

- Per-port transmit stage downstream of the forwarder. Drains one 72-bit output-port FIFO and drives a 64-bit XGMII transmit interface.
- Enforces frame boundaries, inter-frame gap and a maximum frame length.
- Converts FIFO underrun mid-frame into an XGMII error and a clean drop, so a partial frame never reaches the wire as good data.

---
 rtl/xgmii_tx_framer.sv | 154 +++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// Per-port XGMII transmit framer: drains a first-word-fall-through 72-bit FIFO onto XGMII.
// Optional statistics counters are built only when XGMII_TX_STATS_EN is defined.
module xgmii_tx_framer #(
    parameter int          IFG_WORDS = 2,
    parameter logic [11:0] MAX_WORDS = 12'd200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [71:0] dout,
    input  logic        empty,
    output logic        rd_en,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [31:0] tx_frames,
    output logic [31:0] tx_underrun,
    output logic [31:0] tx_dropped
);

    localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
    localparam logic [63:0] ERR_D    = 64'hfefefefefefefefe;
    localparam logic [3:0]  IFG_LOAD = 4'(IFG_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME,
        S_ERR,
        S_DROP,
        S_IFG
    } state_t;

    localparam state_t GAP_STATE = (IFG_WORDS == 0) ? S_IDLE : S_IFG;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_word_cnt, w_word_cnt_nxt;
    logic [3:0]  r_ifg_cnt, w_ifg_cnt_nxt;
    logic [63:0] r_txd, w_txd_nxt;
    logic [7:0]  r_txc, w_txc_nxt;
    logic        w_rd;
    logic        w_is_end;
    logic        w_is_start;

    assign w_is_end   = (dout[71:64] == 8'hff);
    assign w_is_start = dout[64] && (dout[7:0] == 8'hfb) && !w_is_end;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_ifg_cnt_nxt  = r_ifg_cnt;
        w_txd_nxt      = IDLE_D;
        w_txc_nxt      = 8'hff;
        w_rd           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!empty) begin
                    w_rd = 1'b1;
                    if (w_is_start) begin
                        w_txd_nxt      = dout[63:0];
                        w_txc_nxt      = dout[71:64];
                        w_word_cnt_nxt = 12'd1;
                        w_state_nxt    = S_FRAME;
                    end else if (!w_is_end) begin
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_FRAME: begin
                // End detection outranks the length limit, which outranks a normal pop.
                if (empty) begin
                    w_txd_nxt   = ERR_D;
                    w_state_nxt = S_ERR;
                end else if (w_is_end) begin
                    w_rd          = 1'b1;
                    w_ifg_cnt_nxt = IFG_LOAD;
                    w_state_nxt   = GAP_STATE;
                end else if (r_word_cnt == MAX_WORDS) begin
                    w_txd_nxt   = ERR_D;
                    w_state_nxt = S_DROP;
                end else begin
                    w_rd           = 1'b1;
                    w_txd_nxt      = dout[63:0];
                    w_txc_nxt      = dout[71:64];
                    w_word_cnt_nxt = r_word_cnt + 12'd1;
                end
            end
            S_ERR: w_state_nxt = S_DROP;
            S_DROP: begin
                if (!empty) begin
                    w_rd = 1'b1;
                    if (w_is_end) begin
                        w_ifg_cnt_nxt = IFG_LOAD;
                        w_state_nxt   = GAP_STATE;
                    end
                end
            end
            S_IFG: begin
                if (r_ifg_cnt <= 4'd1) w_state_nxt = S_IDLE;
                else                   w_ifg_cnt_nxt = r_ifg_cnt - 4'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rd_en     = w_rd & ~sys_rst;
    assign xgmii_txd = r_txd;
    assign xgmii_txc = r_txc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_word_cnt <= 12'd0;
            r_ifg_cnt  <= 4'd0;
            r_txd      <= IDLE_D;
            r_txc      <= 8'hff;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_ifg_cnt  <= w_ifg_cnt_nxt;
            r_txd      <= w_txd_nxt;
            r_txc      <= w_txc_nxt;
        end
    end

`ifdef XGMII_TX_STATS_EN
    logic        w_frame_inc, w_under_inc, w_drop_inc;
    logic [31:0] r_tx_frames, r_tx_underrun, r_tx_dropped;

    assign w_frame_inc = (r_state == S_FRAME) && !empty && w_is_end;
    assign w_under_inc = (r_state == S_FRAME) && (empty || (!w_is_end && r_word_cnt == MAX_WORDS));
    assign w_drop_inc  = (r_state == S_IDLE) && !empty && !w_is_end && !w_is_start;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tx_frames   <= 32'd0;
            r_tx_underrun <= 32'd0;
            r_tx_dropped  <= 32'd0;
        end else begin
            if (w_frame_inc) r_tx_frames   <= r_tx_frames + 32'd1;
            if (w_under_inc) r_tx_underrun <= r_tx_underrun + 32'd1;
            if (w_drop_inc)  r_tx_dropped  <= r_tx_dropped + 32'd1;
        end
    end

    assign tx_frames   = r_tx_frames;
    assign tx_underrun = r_tx_underrun;
    assign tx_dropped  = r_tx_dropped;
`else
    assign tx_frames   = 32'h0;
    assign tx_underrun = 32'h0;
    assign tx_dropped  = 32'h0;
`endif

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer (IFG_WORDS=3, MAX_WORDS=16) with a queue-based FWFT FIFO model.
// Counter expectations collapse to zero when XGMII_TX_STATS_EN is not defined.
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [71:0] IDLE_W  = {8'hff, IDLE_D};
    localparam logic [71:0] ERR_W   = {8'hff, 64'hfefefefefefefefe};
    localparam logic [71:0] START_W = {8'h01, 56'hd5555555555555, 8'hfb};
    localparam logic [71:0] TERM_W  = {8'hfe, 64'h070707070707fdaa};
    localparam logic [71:0] END_W   = IDLE_W;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [71:0] dout;
    logic        empty;
    logic        rd_en;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] tx_frames, tx_underrun, tx_dropped;

    logic [71:0] q[$];
    logic [71:0] log_w[$];
    logic        log_rd[$];
    logic [71:0] exp_q[$];
    logic        rec = 1'b0;
    logic        fifo_pop;
    int          n_checks = 0;
    int          n_errors = 0;
    int          i0;

    xgmii_tx_framer #(.IFG_WORDS(3), .MAX_WORDS(12'd16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .dout       (dout),
        .empty      (empty),
        .rd_en      (rd_en),
        .xgmii_txd  (xgmii_txd),
        .xgmii_txc  (xgmii_txc),
        .tx_frames  (tx_frames),
        .tx_underrun(tx_underrun),
        .tx_dropped (tx_dropped)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef XGMII_TX_STATS_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    function automatic logic [71:0] data_w(input int k);
        return {8'h00, 64'h0123456700000000 | 64'(k)};
    endfunction

    task automatic drive_fifo();
        empty = (q.size() == 0);
        dout  = empty ? 72'h0 : q[0];
    endtask

    task automatic push(input logic [71:0] w);
        q.push_back(w);
        drive_fifo();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic start_log();
        log_w.delete();
        log_rd.delete();
        rec = 1'b1;
    endtask

    function automatic int first_rd();
        foreach (log_rd[i]) if (log_rd[i]) return i;
        return -1;
    endfunction

    function automatic int count_rd();
        int n = 0;
        foreach (log_rd[i]) if (log_rd[i]) n++;
        return n;
    endfunction

    function automatic int count_nonidle(input int base);
        int n = 0;
        for (int i = base; i < log_w.size(); i++) if (log_w[i] != IDLE_W) n++;
        return n;
    endfunction

    function automatic logic [71:0] nth_nonidle(input int base, input int nth);
        int n = 0;
        for (int i = base; i < log_w.size(); i++) begin
            if (log_w[i] != IDLE_W) begin
                if (n == nth) return log_w[i];
                n++;
            end
        end
        return 72'h0;
    endfunction

    task automatic check_seq(input string tag, input int base);
        foreach (exp_q[k]) check($sformatf("%s[%0d]", tag, k), log_w[base + k], exp_q[k]);
    endtask

    task automatic locate(input string tag);
        i0 = first_rd();
        check(tag, 72'(i0 >= 0), 72'd1);
        if (i0 < 0) i0 = 0;
    endtask

    // FIFO model: pop is decided by rd_en at the edge, head updates just after it.
    initial begin
        drive_fifo();
        forever begin
            @(posedge sys_clk);
            fifo_pop = rd_en;
            #1;
            if (fifo_pop && q.size() != 0) void'(q.pop_front());
            drive_fifo();
        end
    end

    always @(negedge sys_clk) begin
        if (rec) begin
            log_w.push_back({xgmii_txc, xgmii_txd});
            log_rd.push_back(rd_en);
        end
    end

    initial begin
        step(3);
        check("rst_rd_en", 72'(rd_en), 72'd0);
        check("rst_out", {xgmii_txc, xgmii_txd}, IDLE_W);
        check("rst_frames", 72'(tx_frames), 72'd0);
        check("rst_underrun", 72'(tx_underrun), 72'd0);
        check("rst_dropped", 72'(tx_dropped), 72'd0);
        sys_rst = 1'b0;
        step(1);

        // Normal frame: start, 8 data, terminate, end.
        start_log();
        exp_q.delete();
        exp_q.push_back(START_W);
        for (int k = 1; k <= 8; k++) exp_q.push_back(data_w(k));
        exp_q.push_back(TERM_W);
        foreach (exp_q[k]) push(exp_q[k]);
        push(END_W);
        step(20);
        rec = 1'b0;
        locate("t1_pop_seen");
        check_seq("t1_word", i0 + 1);
        check("t1_end_slot", log_w[i0 + 11], IDLE_W);
        check("t1_pops", 72'(count_rd()), 72'd11);
        check("t1_frames", 72'(tx_frames), 72'(exp_cnt(1)));

        // Underrun after four frame words, then a clean recovery frame.
        start_log();
        push(START_W);
        for (int k = 11; k <= 13; k++) push(data_w(k));
        step(8);
        push(data_w(14)); push(data_w(15)); push(TERM_W); push(END_W);
        push(START_W); push(data_w(21)); push(data_w(22)); push(END_W);
        step(25);
        rec = 1'b0;
        locate("t2_pop_seen");
        exp_q.delete();
        exp_q.push_back(START_W);
        for (int k = 11; k <= 13; k++) exp_q.push_back(data_w(k));
        check_seq("t2_word", i0 + 1);
        check("t2_no_pop_empty", 72'(log_rd[i0 + 4]), 72'd0);
        check("t2_error", log_w[i0 + 5], ERR_W);
        check("t2_err_idle", log_w[i0 + 6], IDLE_W);
        check("t2_nonidle_cnt", 72'(count_nonidle(i0 + 6)), 72'd3);
        check("t2_next_start", nth_nonidle(i0 + 6, 0), START_W);
        check("t2_next_d1", nth_nonidle(i0 + 6, 1), data_w(21));
        check("t2_next_d2", nth_nonidle(i0 + 6, 2), data_w(22));
        check("t2_pops", 72'(count_rd()), 72'd12);
        check("t2_underrun", 72'(tx_underrun), 72'(exp_cnt(1)));
        check("t2_frames", 72'(tx_frames), 72'(exp_cnt(2)));

        // Misaligned: idle word, then data without a start word.
        start_log();
        push(END_W); push(data_w(31)); push(data_w(32)); push(END_W);
        step(15);
        rec = 1'b0;
        check("t3_nonidle_cnt", 72'(count_nonidle(0)), 72'd0);
        check("t3_pops", 72'(count_rd()), 72'd4);
        check("t3_fifo_drained", 72'(q.size()), 72'd0);
        check("t3_dropped", 72'(tx_dropped), 72'(exp_cnt(1)));

        // Oversize: 20-word frame against a 16-word limit.
        start_log();
        exp_q.delete();
        exp_q.push_back(START_W);
        for (int k = 41; k <= 55; k++) exp_q.push_back(data_w(k));
        push(START_W);
        for (int k = 41; k <= 59; k++) push(data_w(k));
        push(END_W);
        step(40);
        rec = 1'b0;
        locate("t4_pop_seen");
        check_seq("t4_word", i0 + 1);
        check("t4_no_pop_limit", 72'(log_rd[i0 + 16]), 72'd0);
        check("t4_error", log_w[i0 + 17], ERR_W);
        check("t4_nonidle_after", 72'(count_nonidle(i0 + 18)), 72'd0);
        check("t4_pops", 72'(count_rd()), 72'd21);
        check("t4_fifo_drained", 72'(q.size()), 72'd0);
        check("t4_underrun", 72'(tx_underrun), 72'(exp_cnt(2)));

        // Back-to-back frames: gap of exactly three no-read cycles after the end pop.
        start_log();
        push(START_W); push(data_w(61)); push(data_w(62)); push(END_W);
        push(START_W); push(data_w(71)); push(data_w(72)); push(END_W);
        step(25);
        rec = 1'b0;
        locate("t5_pop_seen");
        exp_q.delete();
        exp_q.push_back(START_W); exp_q.push_back(data_w(61)); exp_q.push_back(data_w(62));
        check_seq("t5_a", i0 + 1);
        check("t5_end_pop", 72'(log_rd[i0 + 3]), 72'd1);
        check("t5_gap", 72'(int'(log_rd[i0 + 4]) + int'(log_rd[i0 + 5]) + int'(log_rd[i0 + 6])), 72'd0);
        check("t5_b_pop", 72'(log_rd[i0 + 7]), 72'd1);
        // The end-word slot plus three gap cycles show as IDLE on the wire.
        check("t5_idle_run", 72'(count_nonidle(i0 + 4) - count_nonidle(i0 + 8)), 72'd0);
        exp_q.delete();
        exp_q.push_back(START_W); exp_q.push_back(data_w(71)); exp_q.push_back(data_w(72));
        check_seq("t5_b", i0 + 8);
        check("t5_frames", 72'(tx_frames), 72'(exp_cnt(4)));

        // Reset in the middle of a frame; leftovers are discarded afterwards.
        push(START_W); push(data_w(81)); push(data_w(82)); push(data_w(83));
        step(2);
        check("t6_pre_rst", {xgmii_txc, xgmii_txd}, data_w(81));
        sys_rst = 1'b1;
        #1;
        check("t6_rst_rd_en", 72'(rd_en), 72'd0);
        step(1);
        check("t6_rst_out", {xgmii_txc, xgmii_txd}, IDLE_W);
        check("t6_rst_frames", 72'(tx_frames), 72'd0);
        check("t6_rst_underrun", 72'(tx_underrun), 72'd0);
        check("t6_rst_dropped", 72'(tx_dropped), 72'd0);
        sys_rst = 1'b0;
        step(3);
        push(END_W);
        step(10);
        check("t6_fifo_drained", 72'(q.size()), 72'd0);
        check("t6_dropped", 72'(tx_dropped), 72'(exp_cnt(1)));
        check("t6_out_idle", {xgmii_txc, xgmii_txd}, IDLE_W);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
